// File: rtl/seg_mux_controller.sv
// Multiplexed N-digit common-anode 7-segment driver with tear-free loads and leading-zero blanking.
// Optional per-slot dimming via `define SEG_DIMMING_EN (adds the 4-bit duty input).
module seg_mux_controller #(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 100000,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef SEG_DIMMING_EN
    input  logic [3:0]              duty,
`endif
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   seg_sel,
    output logic                    frame_done
);

    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PS_W-1:0]         prescaler;
    logic [IDX_W-1:0]        index;
    logic [4*NUM_DIGITS-1:0] shadow_digits, stage_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp, stage_dp;
    logic                    pending;

    logic                    tick, wrap;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    run_zero;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    slot_on;
    logic [7:0]              next_seg;
    logic [NUM_DIGITS-1:0]   next_sel;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign tick = (prescaler == PS_LAST);
    assign wrap = tick && (index == IDX_LAST);

`ifdef SEG_DIMMING_EN
    logic [31:0] on_limit;
    assign on_limit = (32'(CLK_DIV) * {28'd0, duty}) >> 4;
    assign slot_on  = (32'(prescaler) < on_limit);
`else
    assign slot_on = 1'b1;
`endif

    // A digit blanks only if it and every more-significant digit are zero with no dp lit.
    always_comb begin
        blank_mask = '0;
        run_zero   = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run_zero      = run_zero & (shadow_digits[4*i +: 4] == 4'd0) & ~shadow_dp[i];
            blank_mask[i] = run_zero;
        end
    end

    always_comb begin
        cur_nib  = shadow_digits[4*int'(index) +: 4];
        cur_dp   = shadow_dp[index];
        next_sel = ~(NUM_DIGITS'(1) << index);
        next_seg = blank_mask[index] ? 8'hFF : ~{cur_dp, decode(cur_nib)};
        if (!slot_on) begin
            next_sel = '1;
            next_seg = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler     <= '0;
            index         <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            stage_digits  <= '0;
            stage_dp      <= '0;
            pending       <= 1'b0;
            seg           <= 8'hFF;
            seg_sel       <= '1;
            frame_done    <= 1'b0;
        end else begin
            prescaler  <= tick ? '0 : prescaler + 1'b1;
            frame_done <= wrap;
            if (tick)
                index <= wrap ? '0 : index + 1'b1;

            // Shadow only changes at the frame boundary; a load on that very tick bypasses staging.
            if (wrap) begin
                if (load) begin
                    shadow_digits <= digits;
                    shadow_dp     <= dp;
                end else if (pending) begin
                    shadow_digits <= stage_digits;
                    shadow_dp     <= stage_dp;
                end
                pending <= 1'b0;
            end else if (load) begin
                stage_digits <= digits;
                stage_dp     <= dp;
                pending      <= 1'b1;
            end

            seg     <= next_seg;
            seg_sel <= next_sel;
        end
    end

endmodule

// File: tb/tb_seg_mux_controller.sv
// Randomized bench for seg_mux_controller (6 digits, 4 clocks per slot) against a cycle-count reference model.
module tb_seg_mux_controller;

    localparam int N   = 6;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4*N-1:0] digits;
    logic [N-1:0]  dp;
    logic          load;
    logic          blank_lz;
    logic [7:0]    seg;
    logic [N-1:0]  seg_sel;
    logic          frame_done;

    seg_mux_controller #(.NUM_DIGITS(N), .CLK_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .digits(digits), .dp(dp), .load(load),
        .blank_lz(blank_lz), .seg(seg), .seg_sel(seg_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: edges since reset release plus the displayed/staged values.
    int             cnt;
    logic [4*N-1:0] m_shadow_d, m_stage_d;
    logic [N-1:0]   m_shadow_p, m_stage_p;
    bit             m_pending;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cnt);
    endtask

    task automatic model_reset();
        cnt        = 0;
        m_shadow_d = '0;
        m_shadow_p = '0;
        m_stage_d  = '0;
        m_stage_p  = '0;
        m_pending  = 0;
    endtask

    // One clock: drive inputs, predict the registered outputs, compare, advance the model.
    task automatic step(input logic ld, input logic [4*N-1:0] d, input logic [N-1:0] p, input logic blz);
        int       idx, k;
        bit       blank;
        logic [3:0] nib;
        logic [7:0] e_seg;
        logic [N-1:0] e_sel;
        load     = ld;
        digits   = d;
        dp       = p;
        blank_lz = blz;
        idx   = (cnt / DIV) % N;
        nib   = 4'((m_shadow_d >> (4 * idx)) & 24'hF);
        blank = blz && (idx != 0);
        for (int j = idx; j < N; j++)
            if (((m_shadow_d >> (4 * j)) & 24'hF) != 0 || m_shadow_p[j]) blank = 0;
        e_seg = blank ? 8'hFF : ~{m_shadow_p[idx], pat[nib]};
        e_sel = ~(N'(1) << idx);
        @(posedge clk);
        #1;
        k = cnt + 1;
        check("seg", 32'(seg), 32'(e_seg));
        check("seg_sel", 32'(seg_sel), 32'(e_sel));
        check("frame_done", 32'(frame_done), 32'((k % (N * DIV)) == 0));
        if ((k % (N * DIV)) == 0) begin
            if (ld) begin
                m_shadow_d = d;
                m_shadow_p = p;
            end else if (m_pending) begin
                m_shadow_d = m_stage_d;
                m_shadow_p = m_stage_p;
            end
            m_pending = 0;
        end else if (ld) begin
            m_stage_d = d;
            m_stage_p = p;
            m_pending = 1;
        end
        cnt = k;
    endtask

    task automatic idle(input int n, input logic blz);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, 6'h0, blz);
    endtask

    task automatic run_to(input int phase);   // stop so the next edge is at frame position `phase`
        while (((cnt + 1) % (N * DIV)) != phase) step(1'b0, 24'h0, 6'h0, blank_lz);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_sel", 32'(seg_sel), 32'h3F);
        check("rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] r;
        int nz;
        load = 0; digits = '0; dp = '0; blank_lz = 0;
        model_reset();
        do_reset();

        idle(60, 1'b0);

        step(1'b1, 24'h0000A1, 6'h00, 1'b1);
        run_to(0); idle(2 * N * DIV, 1'b1);
        idle(N * DIV, 1'b0);

        run_to(2 * DIV + 1);
        step(1'b1, 24'h654321, 6'h00, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 24'h123456, 6'h00, 1'b0);
        run_to(0); idle(N * DIV + 2, 1'b0);

        run_to(0);
        step(1'b1, 24'hFEDCB9, 6'h2A, 1'b0);
        idle(N * DIV, 1'b0);

        step(1'b1, 24'h000000, 6'b000100, 1'b1);
        run_to(0); idle(N * DIV + 1, 1'b1);

        step(1'b1, 24'h8888AA, 6'h3F, 1'b1);
        do_reset();
        idle(2 * N * DIV + 2, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            nz = $urandom_range(0, N);
            r  = $urandom & ((32'd1 << (4 * nz)) - 1);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            step($urandom_range(0, 9) == 0, r[4*N-1:0],
                 ($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0), blank_lz);
            if (i == 1234) begin
                step(1'b1, 24'h777777, 6'h01, blank_lz);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
